mem_bank: RTL and testbench
===========================

# mem_bank

Main data memory sitting directly downstream of `memBus`. It accepts one read or write at a time on a level-held `rw`/`addr`/`data` request and models a fixed access latency. Reads return with a one-cycle `rdEn` pulse and writes complete with a one-cycle `wbDone` pulse, so the bus can forward both straight to the requesting cache. Initial contents are loaded by testbenches through a hierarchical path.

## Interface
- `WORDW`, default `` `WORDWIDTH ``: data word width.
- `ADDRW`, default `` `ADDRWIDTH ``: address width; depth = 2^ADDRW words.
- `RWW`, default `` `IOSTATEWIDTH ``: request-code width.
- `READ_CODE`, default `` `RWW'd1 ``: `rw` value meaning read.
- `WRITE_CODE`, default `` `RWW'd2 ``: `rw` value meaning write; every other `rw` value means idle.
- `LATENCY`, default 4: cycles from accept to acknowledge; legal range 1..255.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `rwFromBus`, in, RWW: request code, held by the bus until it sees the acknowledge.
- `addrFromBus`, in, ADDRW: word address.
- `dataFromBus`, in, WORDW: write data.
- `dataToBus`, out, WORDW: read data; valid while `rdEnToBus`=1 and held afterwards.
- `rdEnToBus`, out, 1: one-cycle pulse, read data ready.
- `wbDoneToBus`, out, 1: one-cycle pulse, write committed.
- `debugState`, out, 2: FSM state (0 IDLE, 1 BUSY, 2 DONE, 3 RELEASE).
- `debugDelay`, out, 8: remaining latency counter.

## Operation
- Storage is the array `mem[0:2^ADDRW-1]` of WORDW bits. It is not cleared by reset; benches preload it as `mb.bank.mem[i]`.

FSM:
- **IDLE**: if `rwFromBus` equals READ_CODE or WRITE_CODE:
  - latch op, `addr` and `data`;
  - load `cnt` = LATENCY-1;
  - go to BUSY.
- **BUSY**:
  - if `cnt`==0, go to DONE; otherwise decrement `cnt`.
  - Bus inputs are ignored; a change to `rw`, `addr` or `data` mid-access has no effect.
- **Entry to DONE** (same edge):
  - For a read, `dataToBus` ← `mem[latched addr]` and `rdEnToBus` ← 1.
  - For a write, `mem[latched addr]` ← latched data and `wbDoneToBus` ← 1.
- **DONE**: on the next edge the pulse drops. If `rw` is idle, go to IDLE; otherwise go to RELEASE.
- **RELEASE**: wait until `rw` is idle, then go to IDLE. This prevents a still-held request from retriggering.
- Exactly one acknowledge pulse is produced per accepted request.
- Read of a just-written address returns the new value, because the write commits before any later access is accepted.
- An out-of-range `addr` is impossible: depth equals 2^ADDRW.

## Timing
- Reset values (asynchronous): state IDLE, `cnt`=0, `dataToBus`=0, `rdEnToBus`=0, `wbDoneToBus`=0, `debugState`=0, `debugDelay`=0.
- Request sampled at edge k (state IDLE, `rw` active). The acknowledge is high for the cycle after edge k+LATENCY and is deasserted at edge k+LATENCY+1.
- Minimum spacing between acceptances: LATENCY+2 edges. This needs `rw` to drop in the DONE cycle; otherwise the spacing is longer.
- Reset asserted during BUSY:
  - the access is aborted and a pending write is not committed;
  - no acknowledge is produced;
  - the FSM restarts in IDLE after reset is released.
- `rw` going idle during BUSY does not cancel the access; the acknowledge is still produced.
- `dataToBus` changes only on a read's DONE entry or on reset.

## Test plan
- **Basic write then read** (LATENCY=4): write 3 to addr 0, accepted at edge k → `wbDoneToBus`=1 only after edge k+4; the bus releases; read addr 0 → `rdEnToBus` pulses 4 edges after its accept with `dataToBus`=3.
- **Preload and held request**: preload `mem[5]`=16'hA5A5; hold read addr 5 for 20 cycles → exactly one `rdEnToBus` pulse carrying A5A5, and the FSM stays in RELEASE until `rw` goes idle.
- **Inputs changed mid-access**: start write 7 to addr 2; in BUSY change `addr` to 9 and `data` to 1 → `mem[2]`=7 and `mem[9]` unchanged.
- **Reset mid-write**: write 8 to addr 1 with `mem[1]`=0; assert `reset` 2 cycles after accept → no `wbDoneToBus`, `mem[1]` still 0, all outputs 0 immediately (asynchronously).
- **LATENCY=1 back-to-back**: write 4 to addr 0 then read addr 0 → acknowledge 1 edge after each accept, read returns 4, and the two accepts are 3 edges apart.
- **Illegal `rw` code** (value 3): held 10 cycles → FSM stays in IDLE, no pulses.

Source files
------------

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - fixed-latency main data memory behind the memory bus
// One request at a time; read and write acknowledges are single-cycle pulses.

`ifndef WORDWIDTH
`define WORDWIDTH 16
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 8
`endif
`ifndef IOSTATEWIDTH
`define IOSTATEWIDTH 2
`endif

module mem_bank_store #(
  parameter int WORDW = 16,
  parameter int ADDRW = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDRW-1:0] addr,
  input  logic [WORDW-1:0] wdata,
  output logic [WORDW-1:0] rdata
);
  // Deliberately not reset: contents survive reset and are preloaded from outside.
  logic [WORDW-1:0] mem [0:(1<<ADDRW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module mem_bank #(
  parameter int                 WORDW      = `WORDWIDTH,
  parameter int                 ADDRW      = `ADDRWIDTH,
  parameter int                 RWW        = `IOSTATEWIDTH,
  parameter logic [RWW-1:0]     READ_CODE  = RWW'(1),
  parameter logic [RWW-1:0]     WRITE_CODE = RWW'(2),
  parameter int                 LATENCY    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RWW-1:0]   rwFromBus,
  input  logic [ADDRW-1:0] addrFromBus,
  input  logic [WORDW-1:0] dataFromBus,
  output logic [WORDW-1:0] dataToBus,
  output logic             rdEnToBus,
  output logic             wbDoneToBus,
  output logic [1:0]       debugState,
  output logic [7:0]       debugDelay
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, RELEASE = 2'd3} state_t;

  state_t           state, state_next;
  logic [7:0]       cnt, cnt_next;
  logic             op_write, op_write_next;
  logic [ADDRW-1:0] addr_q, addr_next;
  logic [WORDW-1:0] data_q, data_q_next;
  logic [WORDW-1:0] dout_next;
  logic             rd_next, wb_next;
  logic             mem_we;
  logic [WORDW-1:0] mem_rdata;
  logic             rw_active;

  assign rw_active = (rwFromBus == READ_CODE) || (rwFromBus == WRITE_CODE);

  mem_bank_store #(.WORDW(WORDW), .ADDRW(ADDRW)) bank (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr_q),
    .wdata(data_q),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    op_write_next = op_write;
    addr_next     = addr_q;
    data_q_next   = data_q;
    dout_next     = dataToBus;
    rd_next       = 1'b0;
    wb_next       = 1'b0;
    mem_we        = 1'b0;
    case (state)
      IDLE: begin
        if (rw_active) begin
          op_write_next = (rwFromBus == WRITE_CODE);
          addr_next     = addrFromBus;
          data_q_next   = dataFromBus;
          cnt_next      = 8'(LATENCY - 1);
          state_next    = BUSY;
        end
      end
      BUSY: begin
        // Bus inputs are ignored here; only the latched request matters.
        if (cnt == 8'd0) begin
          state_next = DONE;
          if (op_write) begin
            mem_we  = 1'b1;
            wb_next = 1'b1;
          end else begin
            dout_next = mem_rdata;
            rd_next   = 1'b1;
          end
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      DONE: begin
        state_next = rw_active ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!rw_active) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      op_write    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      dataToBus   <= '0;
      rdEnToBus   <= 1'b0;
      wbDoneToBus <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      op_write    <= op_write_next;
      addr_q      <= addr_next;
      data_q      <= data_q_next;
      dataToBus   <= dout_next;
      rdEnToBus   <= rd_next;
      wbDoneToBus <= wb_next;
    end
  end

  assign debugState = state;
  assign debugDelay = cnt;
endmodule

// File: tb/tb_mem_bank.sv
// tb/tb_mem_bank.sv - directed vector bench for mem_bank
module tb_mem_bank;
  localparam int WORDW = 16;
  localparam int ADDRW = 4;
  localparam int RWW   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [RWW-1:0]   rw, rw1;
  logic [ADDRW-1:0] addr, addr1;
  logic [WORDW-1:0] wdata, wdata1;
  logic [WORDW-1:0] dout, dout1;
  logic             rd_en, rd_en1, wb_done, wb_done1;
  logic [1:0]       st, st1;
  logic [7:0]       dly, dly1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bank #(.WORDW(WORDW), .ADDRW(ADDRW), .RWW(RWW), .LATENCY(4)) mb (
    .clk(clk), .reset(reset), .rwFromBus(rw), .addrFromBus(addr), .dataFromBus(wdata),
    .dataToBus(dout), .rdEnToBus(rd_en), .wbDoneToBus(wb_done),
    .debugState(st), .debugDelay(dly)
  );

  mem_bank #(.WORDW(WORDW), .ADDRW(ADDRW), .RWW(RWW), .LATENCY(1)) mb1 (
    .clk(clk), .reset(reset), .rwFromBus(rw1), .addrFromBus(addr1), .dataFromBus(wdata1),
    .dataToBus(dout1), .rdEnToBus(rd_en1), .wbDoneToBus(wb_done1),
    .debugState(st1), .debugDelay(dly1)
  );

  typedef struct {
    logic [RWW-1:0]   rw;
    logic [ADDRW-1:0] addr;
    logic [WORDW-1:0] data;
    logic [1:0]       e_state;
    logic [7:0]       e_delay;
    logic             e_rd;
    logic             e_wb;
    logic [WORDW-1:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [RWW-1:0] r, input logic [ADDRW-1:0] a, input logic [WORDW-1:0] d,
                     input logic [1:0] es, input logic [7:0] ed, input logic erd, input logic ewb,
                     input logic [WORDW-1:0] edo);
    vec_t v;
    v.rw = r; v.addr = a; v.data = d; v.e_state = es; v.e_delay = ed;
    v.e_rd = erd; v.e_wb = ewb; v.e_dout = edo;
    vecs.push_back(v);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int rd_cnt, wb_cnt;
    logic [WORDW-1:0] cap;
    bit seen;

    reset = 1'b1;
    rw = '0; addr = '0; wdata = '0;
    rw1 = '0; addr1 = '0; wdata1 = '0;
    #1;
    chk("reset_state", 32'(st), 0);
    chk("reset_delay", 32'(dly), 0);
    chk("reset_dout", 32'(dout), 0);
    chk("reset_rd", 32'(rd_en), 0);
    chk("reset_wb", 32'(wb_done), 0);
    step();
    reset = 1'b0;
    step();

    // write 3 to addr 0, release, read it back, then illegal code 3
    add(2, 0, 16'd3, 1, 3, 0, 0, 0);
    add(2, 0, 16'd3, 1, 2, 0, 0, 0);
    add(2, 0, 16'd3, 1, 1, 0, 0, 0);
    add(2, 0, 16'd3, 1, 0, 0, 0, 0);
    add(2, 0, 16'd3, 2, 0, 0, 1, 0);
    add(0, 0, 16'd0, 0, 0, 0, 0, 0);
    add(1, 0, 16'd0, 1, 3, 0, 0, 0);
    add(1, 0, 16'd0, 1, 2, 0, 0, 0);
    add(1, 0, 16'd0, 1, 1, 0, 0, 0);
    add(1, 0, 16'd0, 1, 0, 0, 0, 0);
    add(1, 0, 16'd0, 2, 0, 1, 0, 16'd3);
    add(0, 0, 16'd0, 0, 0, 0, 0, 16'd3);
    add(0, 0, 16'd0, 0, 0, 0, 0, 16'd3);
    for (int i = 0; i < vecs.size(); i++) begin
      rw = vecs[i].rw; addr = vecs[i].addr; wdata = vecs[i].data;
      step();
      chk($sformatf("v%0d_state", i), 32'(st), 32'(vecs[i].e_state));
      chk($sformatf("v%0d_delay", i), 32'(dly), 32'(vecs[i].e_delay));
      chk($sformatf("v%0d_rd", i), 32'(rd_en), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_wb", i), 32'(wb_done), 32'(vecs[i].e_wb));
      chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].e_dout));
    end

    // illegal rw code held 10 cycles
    rw = 2'd3; addr = 4'd6; wdata = 16'h5555;
    rd_cnt = 0; wb_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rd_en) rd_cnt++;
      if (wb_done) wb_cnt++;
      chk("illegal_state", 32'(st), 0);
    end
    chk("illegal_pulses", 32'(rd_cnt + wb_cnt), 0);

    // held read of preloaded word
    mb.bank.mem[5] = 16'hA5A5;
    rw = 2'd1; addr = 4'd5;
    rd_cnt = 0; cap = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rd_en) begin
        rd_cnt++;
        cap = dout;
      end
    end
    chk("held_rd_count", 32'(rd_cnt), 1);
    chk("held_rd_data", 32'(cap), 32'h0000A5A5);
    chk("held_release", 32'(st), 3);
    step();
    chk("held_still_release", 32'(st), 3);
    rw = 2'd0;
    step();
    chk("held_back_idle", 32'(st), 0);

    // inputs changed mid-access
    mb.bank.mem[9] = 16'h1234;
    rw = 2'd2; addr = 4'd2; wdata = 16'd7;
    step();
    chk("mid_accept", 32'(st), 1);
    addr = 4'd9; wdata = 16'd1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (wb_done) seen = 1'b1;
    end
    chk("mid_wb_seen", 32'(seen), 1);
    rw = 2'd0;
    step();
    chk("mid_mem2", 32'(mb.bank.mem[2]), 7);
    chk("mid_mem9", 32'(mb.bank.mem[9]), 32'h1234);

    // reset during a write
    mb.bank.mem[1] = 16'd0;
    rw = 2'd2; addr = 4'd1; wdata = 16'd8;
    step();
    step();
    step();
    chk("rst_pre_busy", 32'(st), 1);
    chk("rst_pre_dout", 32'(dout), 32'h0000A5A5);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_state", 32'(st), 0);
    chk("rst_async_delay", 32'(dly), 0);
    chk("rst_async_dout", 32'(dout), 0);
    chk("rst_async_rd", 32'(rd_en), 0);
    chk("rst_async_wb", 32'(wb_done), 0);
    rw = 2'd0;
    step();
    reset = 1'b0;
    wb_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wb_done) wb_cnt++;
    end
    chk("rst_no_wb", 32'(wb_cnt), 0);
    chk("rst_mem1", 32'(mb.bank.mem[1]), 0);
    chk("rst_idle", 32'(st), 0);

    // LATENCY=1 back-to-back write then read
    rw1 = 2'd2; addr1 = 4'd0; wdata1 = 16'd4;
    step();
    chk("l1_w_accept", 32'(st1), 1);
    chk("l1_w_delay", 32'(dly1), 0);
    step();
    chk("l1_w_done", 32'(st1), 2);
    chk("l1_w_wb", 32'(wb_done1), 1);
    rw1 = 2'd0;
    step();
    chk("l1_idle", 32'(st1), 0);
    chk("l1_wb_drop", 32'(wb_done1), 0);
    rw1 = 2'd1; wdata1 = 16'hFFFF;
    step();
    chk("l1_r_accept", 32'(st1), 1);
    step();
    chk("l1_r_rd", 32'(rd_en1), 1);
    chk("l1_r_data", 32'(dout1), 4);
    rw1 = 2'd0;
    step();
    chk("l1_rd_drop", 32'(rd_en1), 0);
    chk("l1_data_held", 32'(dout1), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
